fifo_sync_param: RTL and testbench

Parametrised synchronous FIFO with separate write and read data buses, replacing the bidirectional-bus 32x8 FIFO with its shared front/back address mux.
- Wrap-bit read/write pointers and a dual-port RAM.
- Occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous clear.
- Buffers byte/word streams between producer and consumer logic in the same clock domain.

---
 rtl/fifo_sync_param_pkg.sv | 14 +
 rtl/fifo_sync_param_ram_dp_sync.sv | 35 +++
 rtl/fifo_sync_param.sv | 121 ++++++++++++
 tb/tb_fifo_sync_param.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sync_param_pkg.sv
// Shared defaults for the synchronous FIFO and its RAM: word width, address
// width, watermark levels and the depth derived from the address width.
package fifo_sync_param_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_AF_LEVEL = 28;
    localparam int DEF_AE_LEVEL = 4;

    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/fifo_sync_param_ram_dp_sync.sv
// Simple dual-port RAM: one write port and one registered, enabled read port.
// The storage and the read register have no reset.
module ram_dp_sync
    import fifo_sync_param_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = fifo_depth(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // NOTE: memory arrays get no reset so they map onto RAM macros; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rd_data_q <= mem[raddr];
        end
    end

    assign rdata = rd_data_q;

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO with wrap-bit pointers, occupancy count,
// watermark flags and sticky overflow/underflow errors.
module fifo_sync_param
    import fifo_sync_param_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int AF_LEVEL = DEF_AF_LEVEL,
    parameter int AE_LEVEL = DEF_AE_LEVEL
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Clr,
    input  logic              Wr_en,
    input  logic [DATA_W-1:0] Wr_data,
    input  logic              Rd_en,
    output logic [DATA_W-1:0] Rd_data,
    output logic              Rd_valid,
    output logic              Empty,
    output logic              Full,
    output logic              Almost_full,
    output logic              Almost_empty,
    output logic [ADDR_W:0]   Count,
    output logic              Overflow,
    output logic              Underflow
);

    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] AF_THR  = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_THR  = (ADDR_W+1)'(AE_LEVEL);

    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              rd_valid_q, rd_valid_d;
    logic              has_rd_q, has_rd_d;
    logic              wr_accept, rd_accept;
    logic [DATA_W-1:0] ram_rdata;

    // Flags look only at the registered pointers, never at this cycle's requests.
    assign Empty = (wr_ptr_q == rd_ptr_q);
    assign Full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                   (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    assign Count        = wr_ptr_q - rd_ptr_q;
    assign Almost_full  = (Count >= AF_THR);
    assign Almost_empty = (Count <= AE_THR);

    assign wr_accept = Wr_en & ~Full  & ~Clr;
    assign rd_accept = Rd_en & ~Empty & ~Clr;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        rd_valid_d  = 1'b0;
        has_rd_d    = has_rd_q;
        if (Clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (rd_accept) begin
                rd_ptr_d   = rd_ptr_q + PTR_ONE;
                rd_valid_d = 1'b1;
                has_rd_d   = 1'b1;
            end
            if (Wr_en && Full) begin
                overflow_d = 1'b1;
            end
            if (Rd_en && Empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            has_rd_q    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            rd_valid_q  <= rd_valid_d;
            has_rd_q    <= has_rd_d;
        end
    end

    ram_dp_sync #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (Clk),
        .we   (wr_accept),
        .waddr(wr_ptr_q[ADDR_W-1:0]),
        .wdata(Wr_data),
        .re   (rd_accept),
        .raddr(rd_ptr_q[ADDR_W-1:0]),
        .rdata(ram_rdata)
    );

    // The RAM read register is unreset, so Rd_data reads zero until the first accepted read.
    assign Rd_data   = has_rd_q ? ram_rdata : '0;
    assign Rd_valid  = rd_valid_q;
    assign Overflow  = overflow_q;
    assign Underflow = underflow_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: table-driven fill/drain vectors plus
// hand-written sequences for reset, wrap, boundary simultaneity and clear.
module tb_fifo_sync_param;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       Clr;
    logic       Wr_en;
    logic [7:0] Wr_data;
    logic       Rd_en;
    logic [7:0] Rd_data;
    logic       Rd_valid;
    logic       Empty;
    logic       Full;
    logic       Almost_full;
    logic       Almost_empty;
    logic [5:0] Count;
    logic       Overflow;
    logic       Underflow;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic       wr;
        logic [7:0] wd;
        logic       rd;
        logic       clr;
        logic [5:0] cnt;
        logic       empty;
        logic       full;
        logic       af;
        logic       ae;
        logic       ovf;
        logic       udf;
        logic       rv;
        logic [7:0] rdat;
    } vec_t;

    vec_t vecs[$];

    fifo_sync_param dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .Clr         (Clr),
        .Wr_en       (Wr_en),
        .Wr_data     (Wr_data),
        .Rd_en       (Rd_en),
        .Rd_data     (Rd_data),
        .Rd_valid    (Rd_valid),
        .Empty       (Empty),
        .Full        (Full),
        .Almost_full (Almost_full),
        .Almost_empty(Almost_empty),
        .Count       (Count),
        .Overflow    (Overflow),
        .Underflow   (Underflow)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic wr, input logic [7:0] wd, input logic rd, input logic clr);
        Wr_en   = wr;
        Wr_data = wd;
        Rd_en   = rd;
        Clr     = clr;
        @(posedge Clk);
        #1;
        Wr_en = 1'b0;
        Rd_en = 1'b0;
        Clr   = 1'b0;
    endtask

    function automatic vec_t mk(input logic wr, input logic [7:0] wd, input logic rd,
                                input logic clr, input int cnt, input logic ovf,
                                input logic udf, input logic rv, input logic [7:0] rdat);
        vec_t v;
        v.wr = wr; v.wd = wd; v.rd = rd; v.clr = clr;
        v.cnt   = 6'(cnt);
        v.empty = (cnt == 0);
        v.full  = (cnt == 32);
        v.af    = (cnt >= 28);
        v.ae    = (cnt <= 4);
        v.ovf = ovf; v.udf = udf; v.rv = rv; v.rdat = rdat;
        return v;
    endfunction

    initial begin
        Rst_n = 1'b0; Clr = 1'b0; Wr_en = 1'b0; Rd_en = 1'b0; Wr_data = 8'h00;

        // Fill 32, overflow attempt, drain 32, underflow attempt, clear.
        for (int i = 0; i < 32; i++) vecs.push_back(mk(1, 8'(i), 0, 0, i + 1, 0, 0, 0, 8'h11));
        vecs.push_back(mk(1, 8'hAA, 0, 0, 32, 1, 0, 0, 8'h11));
        for (int i = 0; i < 32; i++) vecs.push_back(mk(0, 8'h00, 1, 0, 31 - i, 1, 0, 1, 8'(i)));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, 1, 0, 8'h1F));
        vecs.push_back(mk(1, 8'h55, 1, 1, 0, 0, 0, 0, 8'h1F));

        #12 Rst_n = 1'b1;

        // Reset mid-cycle: outputs drop without a clock edge.
        step(1, 8'h11, 0, 0);
        step(1, 8'h22, 0, 0);
        step(1, 8'h33, 0, 0);
        step(0, 8'h00, 1, 0);
        check("pre-reset rd_valid", 32'(Rd_valid), 1);
        check("pre-reset rd_data", 32'(Rd_data), 32'h11);
        check("pre-reset count", 32'(Count), 2);
        #3 Rst_n = 1'b0;
        #1;
        check("reset empty", 32'(Empty), 1);
        check("reset almost_empty", 32'(Almost_empty), 1);
        check("reset count", 32'(Count), 0);
        check("reset rd_valid", 32'(Rd_valid), 0);
        check("reset rd_data", 32'(Rd_data), 0);
        check("reset full/af/ovf/udf", {28'd0, Full, Almost_full, Overflow, Underflow}, 0);
        #2 Rst_n = 1'b1;

        // Table vectors; Rd_data held at 0x11 was discarded by reset, so the first
        // read of the table restores meaning. Rd_data is compared only when valid
        // until the first table read has occurred.
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].wr, vecs[i].wd, vecs[i].rd, vecs[i].clr);
            check($sformatf("v%0d count", i), 32'(Count), 32'(vecs[i].cnt));
            check($sformatf("v%0d empty", i), 32'(Empty), 32'(vecs[i].empty));
            check($sformatf("v%0d full", i), 32'(Full), 32'(vecs[i].full));
            check($sformatf("v%0d almost_full", i), 32'(Almost_full), 32'(vecs[i].af));
            check($sformatf("v%0d almost_empty", i), 32'(Almost_empty), 32'(vecs[i].ae));
            check($sformatf("v%0d overflow", i), 32'(Overflow), 32'(vecs[i].ovf));
            check($sformatf("v%0d underflow", i), 32'(Underflow), 32'(vecs[i].udf));
            check($sformatf("v%0d rd_valid", i), 32'(Rd_valid), 32'(vecs[i].rv));
            if (i >= 33) check($sformatf("v%0d rd_data", i), 32'(Rd_data), 32'(vecs[i].rdat));
            else         check($sformatf("v%0d rd_data zero", i), 32'(Rd_data), 0);
        end

        // Wrap and concurrency: 16 writes, 24 overlapped cycles, 16 reads.
        for (int i = 0; i < 16; i++) begin
            step(1, 8'(8'h40 + i), 0, 0);
            check($sformatf("wrap fill%0d count", i), 32'(Count), 32'(i + 1));
        end
        for (int k = 0; k < 24; k++) begin
            step(1, 8'(8'h50 + k), 1, 0);
            check($sformatf("wrap ovl%0d count", k), 32'(Count), 16);
            check($sformatf("wrap ovl%0d rd_valid", k), 32'(Rd_valid), 1);
            check($sformatf("wrap ovl%0d rd_data", k), 32'(Rd_data),
                  (k < 16) ? 32'(8'h40 + k) : 32'(8'h50 + k - 16));
        end
        for (int j = 0; j < 16; j++) begin
            step(0, 8'h00, 1, 0);
            check($sformatf("wrap drain%0d count", j), 32'(Count), 32'(15 - j));
            check($sformatf("wrap drain%0d rd_data", j), 32'(Rd_data), 32'(8'h50 + 8 + j));
        end
        check("wrap empty", 32'(Empty), 1);
        check("wrap no errors", {30'd0, Overflow, Underflow}, 0);

        // Full with simultaneous write and read.
        for (int i = 0; i < 32; i++) step(1, 8'(8'h80 + i), 0, 0);
        check("full before simul", 32'(Full), 1);
        step(1, 8'hEE, 1, 0);
        check("full simul count", 32'(Count), 31);
        check("full simul overflow", 32'(Overflow), 1);
        check("full simul rd_data", 32'(Rd_data), 32'h80);
        check("full simul full", 32'(Full), 0);

        // Empty with simultaneous write and read.
        step(0, 8'h00, 0, 1);
        check("clr empty", 32'(Empty), 1);
        step(1, 8'h5A, 1, 0);
        check("empty simul count", 32'(Count), 1);
        check("empty simul underflow", 32'(Underflow), 1);
        check("empty simul rd_valid", 32'(Rd_valid), 0);
        step(0, 8'h00, 1, 0);
        check("empty simul later read", 32'(Rd_data), 32'h5A);
        check("empty simul later valid", 32'(Rd_valid), 1);

        // Clear priority at Count=10 with Underflow still set.
        for (int i = 0; i < 10; i++) step(1, 8'(8'hC0 + i), 0, 0);
        step(0, 8'h00, 1, 0);
        step(1, 8'hCA, 0, 0);
        check("pre-clr count", 32'(Count), 10);
        check("pre-clr underflow", 32'(Underflow), 1);
        step(1, 8'hFF, 1, 1);
        check("clr count", 32'(Count), 0);
        check("clr empty", 32'(Empty), 1);
        check("clr errors", {30'd0, Overflow, Underflow}, 0);
        check("clr rd_valid", 32'(Rd_valid), 0);
        check("clr rd_data hold", 32'(Rd_data), 32'hC0);
        step(0, 8'h00, 0, 0);
        check("post-clr count", 32'(Count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
